mux_nw_rr: RTL
==============

Name: mux_nw_rr

Overview:
- Parametrised N-channel, W-bit multiplexer with valid/ready handshake on every input and on the output, plus one registered output stage.
- Two selection modes: round-robin arbitration among valid channels, or static select from a `sel` port (a registered, wide, N:1 version of the 2:1 select).
- Sits between several producers (for example, the register-file read or bus sources in npc) and a single consumer. Provides fair sharing and full-throughput back-pressure.

Parameters:
- NCH, 4, number of input channels (2..16; need not be a power of 2)
- W, 8, data width per channel in bits (>=1)
- MODE, 0, 0 = round-robin arbitration, 1 = static select from `sel`
- SELW, $clog2(NCH), derived width of channel index; not overridden

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- sel  input  SELW  channel select, used only when MODE=1
- in_valid  input  NCH  per-channel data valid
- in_data  input  NCH*W  channel i occupies bits [i*W+W-1 : i*W]
- in_ready  output  NCH  per-channel accept, combinational
- out_valid  output  1  output register holds valid data
- out_data  output  W  registered selected data
- out_ch  output  SELW  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0. Any beat in the output register is discarded. in_ready is all 0 while rst_n=0.
- accept = !out_valid || out_ready (combinational). Output register loads only when accept=1.
- Grant, MODE=0:
  - Scan indices ptr, ptr+1, ..., wrapping at NCH (not 2^SELW).
  - The first index with in_valid=1 is the winner.
  - With no valid input there is no winner.
- Grant, MODE=1:
  - The winner is `sel` if sel<NCH and in_valid[sel]=1.
  - If sel>=NCH, there is never a winner and in_ready is all 0.
- in_ready[i]=1 iff accept=1 and i is the winner. At most one bit is set. in_ready never depends on out_data.
- Transfer on input i: in_valid[i] && in_ready[i]. Next cycle: out_data=in_data[i], out_ch=i, out_valid=1.
- If accept=1 and there is no winner: out_valid<=0 next cycle. out_data and out_ch hold their old values.
- Stall: out_valid=1 && out_ready=0 means out_data and out_ch are stable, all in_ready=0, and ptr holds.
- ptr update (MODE=0 only): on a transfer from winner w, ptr <= (w+1) mod NCH. Otherwise ptr holds. In MODE=1, ptr stays 0.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat/cycle with out_ready held high.
- Fairness (MODE=0): with all channels continuously valid, grants go 0,1,...,NCH-1,0,... A continuously valid channel waits at most NCH-1 beats.
- Simultaneous out_ready=1 and a new winner: the old beat is consumed and the new beat is loaded in the same edge. There is no bubble.
- Input rules: inputs are not required to hold valid until ready. in_data is sampled only on transfer.
- Reset mid-operation: it is legal. State returns to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset: drive rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately, without a clock edge. After release, the first grant (all channels valid) is channel 0.
- Round-robin: MODE=0, NCH=4, W=8, all valid, in_data=0x10,0x21,0x32,0x43, out_ready=1 -> out_ch 0,1,2,3,0 on consecutive cycles. out_data follows. No bubbles.
- Sparse and wrap:
  - NCH=3, only ch2 and ch0 valid, ptr=1 -> grant 2, then 0 (wrap at 3, not 4).
  - Then only ch1 valid -> grant 1.
- Back-pressure:
  - Load 0xA5 from ch1, then out_ready=0 for 5 cycles with all inputs valid -> out_data=0xA5 and out_ch=1 stable, in_ready=0, ptr unchanged.
  - Release -> next grant is ch2.
- MODE=1:
  - sel=2, in_data[2]=0x7E, valid -> out_data=0x7E, out_ch=2 after 1 cycle.
  - sel=3 with NCH=3 -> in_ready=000, out_valid drops to 0 after the beat drains.
- Drain: one beat loaded, then all in_valid=0, out_ready=1 -> out_valid=1 for exactly one cycle, then 0. out_data keeps its last value.

Source files
------------

// File: rtl/mux_nw_rr.sv
// N-channel, W-bit valid/ready multiplexer with one registered output stage.
// Selection is round-robin among valid channels (MODE=0) or static from sel (MODE=1).
module mux_nw_rr #(
    parameter int NCH  = 4,
    parameter int W    = 8,
    parameter int MODE = 0,
    parameter int SELW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SELW-1:0]   sel,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*W-1:0]  in_data,
    output logic [NCH-1:0]    in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_ch,
    input  logic              out_ready
);

    logic            r_valid;
    logic [W-1:0]    r_data;
    logic [SELW-1:0] r_ch;
    logic [SELW-1:0] r_ptr;

    logic            w_accept;
    logic            w_hiHit;
    logic [SELW-1:0] w_hiIdx;
    logic            w_loHit;
    logic [SELW-1:0] w_loIdx;
    logic            w_selHit;
    logic            w_found;
    logic [SELW-1:0] w_win;
    logic [SELW-1:0] w_ptrNext;
    logic [W-1:0]    w_data;
    logic [NCH-1:0]  w_grant;

    assign w_accept = !r_valid || out_ready;

    // Round-robin: the lowest valid index at or above ptr wins; if there is none,
    // the lowest valid index overall wins, which wraps the scan at NCH.
    always_comb begin
        w_hiHit  = 1'b0;
        w_hiIdx  = '0;
        w_loHit  = 1'b0;
        w_loIdx  = '0;
        w_selHit = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                w_loHit = 1'b1;
                w_loIdx = SELW'(i);
                if (SELW'(i) >= r_ptr) begin
                    w_hiHit = 1'b1;
                    w_hiIdx = SELW'(i);
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if ((SELW'(i) == sel) && in_valid[i]) begin
                w_selHit = 1'b1;
            end
        end
        if (MODE == 0) begin
            w_found = w_hiHit || w_loHit;
            w_win   = w_hiHit ? w_hiIdx : w_loIdx;
        end else begin
            w_found = w_selHit;
            w_win   = sel;
        end
    end

    always_comb begin
        w_data  = '0;
        w_grant = '0;
        for (int i = 0; i < NCH; i++) begin
            if (SELW'(i) == w_win) begin
                w_data     = in_data[i*W +: W];
                w_grant[i] = 1'b1;
            end
        end
    end

    assign w_ptrNext = (w_win == SELW'(NCH - 1)) ? '0 : (w_win + SELW'(1));

    assign in_ready = (rst_n && w_accept && w_found) ? w_grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            if (w_found) begin
                r_valid <= 1'b1;
                r_data  <= w_data;
                r_ch    <= w_win;
                if (MODE == 0) begin
                    r_ptr <= w_ptrNext;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_ch    = r_ch;

endmodule
